// File: rtl/spi_slave_param_if.sv
// SPI-side and RAM-side signal bundle for spi_slave_param.
// Widths follow the same ADDR_W/DATA_W parameters as the slave instance.
interface spi_slave_param_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    localparam int PAYLOAD_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int FRAME_W   = PAYLOAD_W + 2;

    // SS_n/MOSI are sampled on every rising clk edge.
    // tx_valid is a one-sided strobe: it is only looked at while the slave
    // waits for read data, and there is no ready back towards the RAM.
    // rx_valid and frame_err are single-cycle pulses with no backpressure.
    logic                SS_n;
    logic                MOSI;
    logic [DATA_W-1:0]   tx_data;
    logic                tx_valid;
    logic [FRAME_W-1:0]  rx_data;
    logic                rx_valid;
    logic                MISO;
    logic                frame_err;
    logic                busy;
    logic [2:0]          dbg_state;

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  rx_data, rx_valid, MISO, frame_err, busy, dbg_state
    );

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output rx_data, rx_valid, MISO, frame_err, busy, dbg_state
    );
endinterface

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave front-end: MOSI frames -> {opcode, payload} words,
// RAM read data -> MISO, with tx wait timeout and frame-abort reporting.
module spi_slave_param #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int TX_TIMEOUT = 16
) (
    input logic              clk,
    input logic              rst,
    spi_slave_param_if.slave bus
);
    localparam int PAYLOAD_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int FRAME_W   = PAYLOAD_W + 2;
    localparam int CNT_W     = $clog2(FRAME_W + 1);
    localparam int IDX_W     = $clog2(FRAME_W);
    localparam int TO_W      = $clog2(TX_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CHK_CMD   = 3'd1,
        S_WRITE     = 3'd2,
        S_READ_ADD  = 3'd3,
        S_READ_DATA = 3'd4,
        S_WAIT_TX   = 3'd5,
        S_SEND      = 3'd6,
        S_DONE      = 3'd7
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [TO_W-1:0]    r_tcnt;
    logic [DATA_W-1:0]  r_shreg;
    logic [FRAME_W-1:0] r_rx_data;
    logic               r_rx_valid;
    logic               r_frame_err;
    logic               r_miso;
    logic               r_addr_pending;

    logic               w_abort;
    logic               w_shift_in;
    logic               w_last_bit;
    logic               w_capture;
    logic               w_timeout;
    logic               w_shift_out;
    logic               w_clr_pend;
    logic [IDX_W-1:0]   w_rx_idx;

    always_comb begin
        w_next      = r_state;
        w_abort     = 1'b0;
        w_shift_in  = 1'b0;
        w_last_bit  = (r_cnt == CNT_W'(1));
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        w_shift_out = 1'b0;
        w_clr_pend  = 1'b0;
        w_rx_idx    = IDX_W'(r_cnt - CNT_W'(1));
        // SS_n high wins over any sampling, including the final bit edge.
        if ((r_state != S_IDLE) && bus.SS_n) begin
            w_next     = S_IDLE;
            w_abort    = (r_state != S_DONE);
            w_clr_pend = (r_state == S_WAIT_TX) || (r_state == S_SEND);
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (!bus.SS_n) w_next = S_CHK_CMD;
                end
                S_CHK_CMD: begin
                    if (!bus.MOSI)          w_next = S_WRITE;
                    else if (r_addr_pending) w_next = S_READ_DATA;
                    else                    w_next = S_READ_ADD;
                end
                S_WRITE, S_READ_ADD, S_READ_DATA: begin
                    w_shift_in = 1'b1;
                    if (w_last_bit) w_next = (r_state == S_READ_DATA) ? S_WAIT_TX : S_DONE;
                end
                S_WAIT_TX: begin
                    if (bus.tx_valid) begin
                        w_capture = 1'b1;
                        w_next    = S_SEND;
                    end else if (r_tcnt == TO_W'(TX_TIMEOUT - 1)) begin
                        w_timeout  = 1'b1;
                        w_clr_pend = 1'b1;
                        w_next     = S_DONE;
                    end
                end
                S_SEND: begin
                    w_shift_out = 1'b1;
                    if (w_last_bit) begin
                        w_clr_pend = 1'b1;
                        w_next     = S_DONE;
                    end
                end
                S_DONE: begin
                    w_next = S_DONE;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt          <= '0;
            r_tcnt         <= '0;
            r_shreg        <= '0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_frame_err    <= 1'b0;
            r_miso         <= 1'b0;
            r_addr_pending <= 1'b0;
        end else begin
            r_rx_valid  <= w_shift_in && w_last_bit;
            r_frame_err <= w_abort || w_timeout;

            if (r_state == S_CHK_CMD)        r_cnt <= CNT_W'(FRAME_W);
            else if (w_capture)              r_cnt <= CNT_W'(DATA_W);
            else if (w_shift_in || w_shift_out) r_cnt <= r_cnt - CNT_W'(1);

            if (w_shift_in) r_rx_data[w_rx_idx] <= bus.MOSI;

            // Timeout counter restarts for every READ_DATA frame.
            if (r_state == S_READ_DATA)    r_tcnt <= '0;
            else if (r_state == S_WAIT_TX) r_tcnt <= r_tcnt + TO_W'(1);

            if (w_clr_pend)
                r_addr_pending <= 1'b0;
            else if ((r_state == S_READ_ADD) && w_shift_in && w_last_bit)
                r_addr_pending <= 1'b1;

            if (w_capture)        r_shreg <= bus.tx_data;
            else if (w_shift_out) r_shreg <= r_shreg << 1;

            if (w_next == S_IDLE)  r_miso <= 1'b0;
            else if (w_shift_out)  r_miso <= r_shreg[DATA_W-1];
        end
    end

    assign bus.rx_data   = r_rx_data;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.MISO      = r_miso;
    assign bus.frame_err = r_frame_err;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: directed and random frames on an 8/8 and a 10/16
// instance, scoreboarded against a transaction-level model.
module tb_spi_slave_param;
    localparam int TO = 16;
    localparam logic [2:0] ST_WAIT_TX = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_slave_param_if #(.ADDR_W(8),  .DATA_W(8))  bus_a();
    spi_slave_param_if #(.ADDR_W(10), .DATA_W(16)) bus_b();

    spi_slave_param #(.ADDR_W(8), .DATA_W(8), .TX_TIMEOUT(TO)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    spi_slave_param #(.ADDR_W(10), .DATA_W(16), .TX_TIMEOUT(TO)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] exp_rx_q[$];
    logic [31:0] exp_tx_q[$];
    logic [31:0] exp_err_q[$];

    logic m_pend[2];
    int   last_rx_cyc  = 0;
    int   last_err_cyc = 0;
    int   frame_start  = 0;
    int   wait_entry   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %0h, expected nothing (t=%0t)", name, act, $time);
    endtask

    // ---------------- clock/reset helpers and drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ss(input int sel, input logic v);
        if (sel == 0) bus_a.SS_n = v; else bus_b.SS_n = v;
    endtask

    task automatic set_mosi(input int sel, input logic v);
        if (sel == 0) bus_a.MOSI = v; else bus_b.MOSI = v;
    endtask

    task automatic set_tx(input int sel, input logic v, input logic [31:0] d);
        if (sel == 0) begin
            bus_a.tx_valid = v;
            bus_a.tx_data  = d[7:0];
        end else begin
            bus_b.tx_valid = v;
            bus_b.tx_data  = d[15:0];
        end
    endtask

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? bus_a.busy : bus_b.busy;
    endfunction

    function automatic logic [2:0] get_state(input int sel);
        return (sel == 0) ? bus_a.dbg_state : bus_b.dbg_state;
    endfunction

    // wait_mode: 0 = tx after tx_delay idle edges (>= TO times out),
    //            1 = SS_n raised at WAIT_TX edge tx_delay (1..TO),
    //            2 = async reset a few bits into SEND.
    task automatic do_frame(input int sel, input logic dir, input logic [31:0] frame,
                            input int abort_edge, input int wait_mode, input int tx_delay,
                            input logic [31:0] tx_word, input int extra);
        int          fw     = (sel == 0) ? 10 : 18;
        int          dw     = (sel == 0) ? 8 : 16;
        logic [31:0] fmask  = (32'd1 << fw) - 32'd1;
        logic [31:0] dmask  = (32'd1 << dw) - 32'd1;
        int          kind;
        logic        aborted = 1'b0;

        // Reference model: what this frame must produce.
        kind = (dir == 1'b0) ? 0 : (m_pend[sel] ? 2 : 1);
        if (abort_edge >= 0) begin
            exp_err_q.push_back(32'd1);
        end else begin
            exp_rx_q.push_back(frame & fmask);
            if (kind == 1) m_pend[sel] = 1'b1;
            if (kind == 2) begin
                m_pend[sel] = 1'b0;
                if (wait_mode == 1 || (wait_mode == 0 && tx_delay >= TO))
                    exp_err_q.push_back(32'd1);
                else if (wait_mode == 0)
                    exp_tx_q.push_back(tx_word & dmask);
            end
        end

        frame_start = cyc;
        set_ss(sel, 1'b0);
        set_mosi(sel, 1'($urandom_range(0, 1)));
        tick();
        set_mosi(sel, dir);
        if (abort_edge == 0) set_ss(sel, 1'b1);
        tick();
        aborted = (abort_edge == 0);
        for (int i = 0; i < fw && !aborted; i++) begin
            set_mosi(sel, frame[fw-1-i]);
            if (abort_edge == i + 1) set_ss(sel, 1'b1);
            tick();
            aborted = (abort_edge == i + 1);
        end
        if (aborted) begin
            check("abort_to_idle", 32'(get_busy(sel)), 32'd0);
            tick();
            return;
        end

        wait_entry = cyc;
        check("post_frame_state", 32'(get_state(sel)), (kind == 2) ? 32'(ST_WAIT_TX) : 32'(ST_DONE));

        if (kind != 2) begin
            for (int i = 0; i < extra; i++) begin
                set_mosi(sel, 1'($urandom_range(0, 1)));
                tick();
            end
            check("busy_in_done", 32'(get_busy(sel)), 32'd1);
            set_ss(sel, 1'b1);
            tick();
            check("busy_after_ss", 32'(get_busy(sel)), 32'd0);
            return;
        end

        if (wait_mode == 1) begin
            for (int i = 1; i < tx_delay; i++) begin
                set_tx(sel, 1'b0, $urandom);
                tick();
            end
            set_ss(sel, 1'b1);
            tick();
            check("wait_abort_idle", 32'(get_busy(sel)), 32'd0);
        end else if (wait_mode == 2) begin
            set_tx(sel, 1'b1, tx_word);
            tick();
            set_tx(sel, 1'b0, 32'd0);
            repeat (3) tick();
            check("miso_before_rst", 32'(bus_a.MISO), 32'd1);
            #2 rst = 1'b1;
            #1;
            check("rst_miso",  32'(bus_a.MISO),      32'd0);
            check("rst_rxv",   32'(bus_a.rx_valid),  32'd0);
            check("rst_err",   32'(bus_a.frame_err), 32'd0);
            check("rst_busy",  32'(bus_a.busy),      32'd0);
            tick();
            rst = 1'b0;
            m_pend[0] = 1'b0;
            m_pend[1] = 1'b0;
            set_ss(sel, 1'b1);
            tick();
        end else if (tx_delay >= TO) begin
            for (int i = 0; i < TO; i++) begin
                set_tx(sel, 1'b0, $urandom);
                tick();
            end
            check("timeout_done", 32'(get_state(sel)), 32'(ST_DONE));
            set_ss(sel, 1'b1);
            tick();
        end else begin
            for (int i = 0; i < tx_delay; i++) begin
                set_tx(sel, 1'b0, $urandom);
                tick();
            end
            set_tx(sel, 1'b1, tx_word);
            tick();
            set_tx(sel, 1'b0, $urandom);
            repeat (dw) tick();
            check("send_done", 32'(get_state(sel)), 32'(ST_DONE));
            tick();
            set_ss(sel, 1'b1);
            tick();
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int          col_pos[2]  = '{-2, -2};
    logic [31:0] col_word[2] = '{32'd0, 32'd0};

    task automatic mon(input int sel, input logic rxv, input logic [31:0] rxd, input logic err,
                       input logic miso, input logic txv, input int dw);
        logic [31:0] e;
        if (rst) begin
            col_pos[sel] = -2;
            return;
        end
        if (rxv && err) fail("rxv_err_overlap", 32'd1);
        if (rxv) begin
            if (exp_rx_q.size() == 0) fail("rx_unexpected", rxd);
            else begin
                e = exp_rx_q.pop_front();
                check("rx_data", rxd, e);
                last_rx_cyc = cyc;
            end
        end
        if (err) begin
            if (exp_err_q.size() == 0) fail("frame_err_unexpected", 32'd1);
            else begin
                e = exp_err_q.pop_front();
                check("frame_err", 32'(err), e);
                last_err_cyc = cyc;
            end
        end
        if (col_pos[sel] >= 0) begin
            col_word[sel] = {col_word[sel][30:0], miso};
            col_pos[sel]++;
            if (col_pos[sel] == dw) begin
                col_pos[sel] = -2;
                if (exp_tx_q.size() == 0) fail("miso_unexpected", col_word[sel]);
                else begin
                    e = exp_tx_q.pop_front();
                    check("miso_word", col_word[sel], e);
                end
            end
        end else if (col_pos[sel] == -1) begin
            col_pos[sel] = 0;
        end
        if (txv && col_pos[sel] == -2) begin
            col_pos[sel]  = -1;
            col_word[sel] = 32'd0;
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus_a.rx_valid, 32'(bus_a.rx_data), bus_a.frame_err, bus_a.MISO, bus_a.tx_valid, 8);
        mon(1, bus_b.rx_valid, 32'(bus_b.rx_data), bus_b.frame_err, bus_b.MISO, bus_b.tx_valid, 16);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic random_frames(input int sel, input int n);
        int fw = (sel == 0) ? 10 : 18;
        int ab, wm, d;
        for (int k = 0; k < n; k++) begin
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, fw)) : -1;
            wm = ($urandom_range(0, 5) == 0) ? 1 : 0;
            d  = (wm == 1) ? int'($urandom_range(1, TO)) : int'($urandom_range(0, TO + 1));
            do_frame(sel, 1'($urandom_range(0, 1)), $urandom, ab, wm, d, $urandom,
                     int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        rst = 1'b1;
        m_pend[0] = 1'b0;
        m_pend[1] = 1'b0;
        bus_a.SS_n = 1'b1; bus_a.MOSI = 1'b0; bus_a.tx_valid = 1'b0; bus_a.tx_data = '0;
        bus_b.SS_n = 1'b1; bus_b.MOSI = 1'b0; bus_b.tx_valid = 1'b0; bus_b.tx_data = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("reset_rx_data",   32'(bus_a.rx_data),   32'd0);
        check("reset_rx_valid",  32'(bus_a.rx_valid),  32'd0);
        check("reset_miso",      32'(bus_a.MISO),      32'd0);
        check("reset_frame_err", 32'(bus_a.frame_err), 32'd0);
        check("reset_busy",      32'(bus_a.busy),      32'd0);
        check("reset_b_rx_data", 32'(bus_b.rx_data),   32'd0);
        check("reset_b_busy",    32'(bus_b.busy),      32'd0);

        // Write frame and its rx_valid latency.
        do_frame(0, 1'b0, 32'h0A5, -1, 0, 0, 0, 2);
        check("rx_latency", 32'(last_rx_cyc - frame_start), 32'd12);

        // Address frame, then data frame returning 0x3C.
        do_frame(0, 1'b1, 32'h210, -1, 0, 0, 0, 1);
        do_frame(0, 1'b1, 32'h300, -1, 0, 0, 32'h3C, 0);

        // Write aborted after 4 payload bits.
        do_frame(0, 1'b0, 32'h155, 5, 0, 0, 0, 0);
        check("abort_err_cycle", 32'(last_err_cyc - frame_start), 32'd7);

        // Timeout with tx_valid held low, then a read lands in READ_ADD again.
        do_frame(0, 1'b1, 32'h2AA, -1, 0, 0, 0, 0);
        do_frame(0, 1'b1, 32'h3C3, -1, 0, TO, 0, 0);
        check("timeout_cycle", 32'(last_err_cyc - wait_entry), 32'(TO));
        do_frame(0, 1'b1, 32'h201, -1, 0, 0, 0, 0);

        // tx_valid on the same edge the timeout would expire.
        do_frame(0, 1'b1, 32'h0F0, -1, 0, TO - 1, 32'hA7, 0);

        // SS_n rising together with the final payload bit.
        do_frame(0, 1'b0, 32'h3FF, 10, 0, 0, 0, 0);

        random_frames(0, 40);
        if (m_pend[0]) do_frame(0, 1'b1, 32'h111, -1, 0, 2, 32'h5A, 0);

        // Wide instance: 18-bit frames, 16-bit read data.
        do_frame(1, 1'b0, 32'h1BEEF, -1, 0, 0, 0, 1);
        do_frame(1, 1'b1, 32'h203FF, -1, 0, 0, 0, 0);
        do_frame(1, 1'b1, 32'h30000, -1, 0, 3, 32'h8001, 0);
        random_frames(1, 15);

        // Async reset in the middle of SEND.
        if (!m_pend[0]) do_frame(0, 1'b1, 32'h2C4, -1, 0, 0, 0, 0);
        do_frame(0, 1'b1, 32'h3C4, -1, 2, 0, 32'hFF, 0);
        do_frame(0, 1'b1, 32'h2E1, -1, 0, 0, 0, 0);

        repeat (4) tick();
        check("rx_q_drained",  32'(exp_rx_q.size()),  32'd0);
        check("tx_q_drained",  32'(exp_tx_q.size()),  32'd0);
        check("err_q_drained", 32'(exp_err_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_slave_param.md
Name: spi_slave_param

Overview:
- Parametrised SPI slave front-end for the single-port RAM wrapper.
- Deserialises MOSI frames into {opcode, payload} words for the RAM, and serialises RAM read data onto MISO.
- Successor to the fixed 10-bit slave. Adds:
  - configurable address/data widths;
  - single-cycle rx_valid pulses;
  - a tx_valid wait timeout;
  - explicit frame-abort error reporting.
- SCK is the system clock: one bit per clk edge while SS_n is low.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 8, RAM data width; also the number of MISO bits per read.
- TX_TIMEOUT, 16, max cycles spent in WAIT_TX before abort; must be >= 1.
- Derived (localparam): PAYLOAD_W = max(ADDR_W, DATA_W); FRAME_W = PAYLOAD_W + 2.

Ports:
- clk       in   1          system clock; all logic on rising edge
- rst       in   1          asynchronous, active-high reset
- SS_n      in   1          slave select, active low
- MOSI      in   1          serial data in, MSB first
- tx_data   in   DATA_W     read data from RAM
- tx_valid  in   1          tx_data valid; sampled only in WAIT_TX
- rx_data   out  FRAME_W    {opcode[1:0], payload[PAYLOAD_W-1:0]}; payload right-justified
- rx_valid  out  1          one-cycle pulse: rx_data complete
- MISO      out  1          serial data out, MSB first
- frame_err out  1          one-cycle pulse: aborted frame or tx timeout
- busy      out  1          high whenever state != IDLE

Behaviour:
- Reset (async, immediate, valid mid-operation):
  - state = IDLE, rx_data = 0, rx_valid = 0, MISO = 0, frame_err = 0.
  - Internal: addr_pending = 0, counters = 0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SEND, DONE.
- IDLE:
  - SS_n low at an edge -> CHK_CMD.
  - MISO driven 0.
- CHK_CMD:
  - MOSI at the edge is the direction bit; it is not stored.
  - 0 -> WRITE.
  - 1 with addr_pending = 0 -> READ_ADD.
  - 1 with addr_pending = 1 -> READ_DATA.
  - bit counter loaded with FRAME_W.
- WRITE / READ_ADD / READ_DATA:
  - Each edge: rx_data[cnt-1] <= MOSI, cnt decrements.
  - On the edge sampling bit 0, rx_valid is set; it is high for exactly the following cycle.
  - READ_ADD additionally sets addr_pending; next state DONE.
  - WRITE next state DONE.
  - READ_DATA next state WAIT_TX, with the timeout counter cleared.
- WAIT_TX:
  - Edge with tx_valid = 1: capture tx_data into the shift register -> SEND, bit counter = DATA_W.
  - After TX_TIMEOUT edges without tx_valid:
    - frame_err pulses one cycle;
    - addr_pending is cleared;
    - next state DONE.
- SEND:
  - Each edge: MISO <= shreg[cnt-1], cnt decrements.
  - First MISO bit (MSB) appears the cycle after capture.
  - After the DATA_W-th bit: addr_pending cleared -> DONE.
- DONE:
  - Waits for SS_n high; extra MOSI bits are ignored.
  - MISO holds its last value.
- SS_n high at any edge, in any non-IDLE state -> IDLE.
  - If the state is CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX or SEND, the frame is aborted:
    - frame_err pulses one cycle;
    - rx_valid is not asserted;
    - addr_pending is unchanged (except WAIT_TX/SEND abort, which clears it);
    - rx_data keeps its partially shifted contents.
  - SS_n high in DONE: no error.
- Simultaneity:
  - SS_n rising on the same edge as the final sample bit: the bit is lost and the frame is aborted (SS_n has priority).
  - tx_valid and the timeout expiring on the same edge: tx_valid wins.
- rx_valid and frame_err are never high in the same cycle.
- A second address frame while addr_pending = 1 is impossible: a dir = 1 frame always goes to READ_DATA.

Test Plan:
- Reset, then SS_n low, dir = 0, payload bits 00_1010_0101 -> rx_data = 10'h0A5; rx_valid high exactly one cycle, 12 cycles after SS_n fall; busy = 1 until SS_n high.
- dir = 1, frame 10_0001_0000 -> rx_data = 10'h210 with rx_valid pulse (addr_pending set). Next transaction: dir = 1, frame 11_0000_0000 -> rx_valid pulse, then tx_valid = 1 with tx_data = 8'h3C -> MISO = 0,0,1,1,1,1,0,0 on the following 8 cycles.
- Write frame with SS_n raised after 4 payload bits -> frame_err one-cycle pulse, rx_valid never high, state IDLE next cycle.
- READ_DATA frame with tx_valid held 0 -> frame_err exactly 16 cycles after WAIT_TX entry. Next dir = 1 frame enters READ_ADD (addr_pending cleared).
- ADDR_W = 10, DATA_W = 16: write frame 01 + 16'hBEEF -> rx_data = 18'h1BEEF. Read returning 16'h8001 -> MISO 1, fourteen 0s, 1.
- rst asserted mid-SEND (between clock edges) -> MISO, rx_valid, frame_err and busy are 0 immediately. After release, a dir = 1 frame enters READ_ADD.
